// File: rtl/multicycle_control.sv
// multicycle_control
// Multi-cycle sequencer for an ARMv8-subset datapath. One instruction at a
// time walks IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB]. Instruction
// and data memories may stall with wait states; a stall that lasts
// MEM_TIMEOUT cycles is a fault. The block also keeps the retired-instruction
// counter and the sticky fault / halt status.
//
// Handshake: a memory request (imem_req / dmem_req) is raised on entry to
// FETCH / MEM and held, together with every other strobe of that state,
// until the cycle in which the matching ack is seen high. That cycle
// completes the access; the request is never dropped early unless the wait
// budget expires, in which case the sequencer halts.
//
// Ports
//   CLK, resetl            clock (rising edge), asynchronous active-low reset
//   run                    level; allows leaving IDLE and continuing after a retire
//   opcode[10:0]           IR[31:21], sampled in DECODE
//   zero                   ALU zero flag, used by CBZ in EXEC
//   imem_req / imem_ack    instruction fetch handshake
//   dmem_req / dmem_ack    data access handshake
//   ir_write, pc_write     1-cycle load strobes for IR and PC
//   pc_src                 0 = PC+4, 1 = branch target
//   reg2loc, alusrc, mem2reg, regwrite, memread, memwrite, aluop, signop
//                          datapath controls
//   instret                retired-instruction count (wraps)
//   fault                  sticky: illegal opcode or memory timeout
//   halted                 sequencer is in HALT
//   state_dbg              current FSM state encoding
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             resetl,
    input  logic             run,
    input  logic [10:0]      opcode,
    input  logic             zero,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    input  logic             dmem_ack,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg2loc,
    output logic             alusrc,
    output logic             mem2reg,
    output logic             regwrite,
    output logic             memread,
    output logic             memwrite,
    output logic [3:0]       aluop,
    output logic [2:0]       signop,
    output logic [CNT_W-1:0] instret,
    output logic             fault,
    output logic             halted,
    output logic [2:0]       state_dbg
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        C_AND, C_ORR, C_ADD, C_SUB, C_ADDI, C_SUBI,
        C_MOVZ, C_B, C_CBZ, C_LDUR, C_STUR
    } cls_e;

    state_e            state_q, state_d;
    cls_e              cls_q, cls_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              fault_q, fault_d;

    cls_e              dec_cls;
    logic              dec_ok;
    logic              retire;
    logic [3:0]        ex_aluop;
    logic              ex_alusrc, ex_reg2loc;
    logic [2:0]        ex_signop;

    // Opcode classifier; earlier patterns take priority over later ones.
    always_comb begin
        dec_cls = C_AND;
        dec_ok  = 1'b1;
        if      (opcode ==? 11'b?0001010???) dec_cls = C_AND;
        else if (opcode ==? 11'b?0101010???) dec_cls = C_ORR;
        else if (opcode ==? 11'b?0?01011???) dec_cls = C_ADD;
        else if (opcode ==? 11'b?1?01011???) dec_cls = C_SUB;
        else if (opcode ==? 11'b?0?10001???) dec_cls = C_ADDI;
        else if (opcode ==? 11'b?1?10001???) dec_cls = C_SUBI;
        else if (opcode ==? 11'b110100101??) dec_cls = C_MOVZ;
        else if (opcode ==? 11'b?00101?????) dec_cls = C_B;
        else if (opcode ==? 11'b?011010????) dec_cls = C_CBZ;
        else if (opcode ==? 11'b??111000010) dec_cls = C_LDUR;
        else if (opcode ==? 11'b??111000000) dec_cls = C_STUR;
        else                                 dec_ok  = 1'b0;
    end

    // ALU/immediate controls for the latched class. They are driven from
    // EXEC through MEM and WB so the ALU result stays valid until written.
    always_comb begin
        ex_aluop   = 4'b0000;
        ex_alusrc  = 1'b0;
        ex_signop  = 3'b000;
        ex_reg2loc = 1'b0;
        case (cls_q)
            C_AND:  ex_aluop = 4'b0000;
            C_ORR:  ex_aluop = 4'b0001;
            C_ADD:  ex_aluop = 4'b0010;
            C_SUB:  ex_aluop = 4'b0110;
            C_ADDI: begin ex_aluop = 4'b0010; ex_alusrc = 1'b1; ex_signop = 3'b010; end
            C_SUBI: begin ex_aluop = 4'b0110; ex_alusrc = 1'b1; ex_signop = 3'b010; end
            C_MOVZ: begin ex_aluop = 4'b0111; ex_alusrc = 1'b1; ex_signop = 3'b100; end
            C_B:    ex_signop = 3'b000;
            C_CBZ:  begin ex_aluop = 4'b0111; ex_reg2loc = 1'b1; ex_signop = 3'b001; end
            C_LDUR: begin ex_aluop = 4'b0010; ex_alusrc = 1'b1; ex_signop = 3'b011; end
            C_STUR: begin
                ex_aluop = 4'b0010; ex_alusrc = 1'b1; ex_signop = 3'b011; ex_reg2loc = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q   <= S_IDLE;
            cls_q     <= C_AND;
            wait_q    <= '0;
            instret_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        wait_d   = wait_q;
        fault_d  = fault_q;
        retire   = 1'b0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_src   = 1'b0;
        reg2loc  = 1'b0;
        alusrc   = 1'b0;
        mem2reg  = 1'b0;
        regwrite = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        aluop    = 4'b0000;
        signop   = 3'b000;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                if (dec_ok) begin
                    cls_d   = dec_cls;
                    state_d = S_EXEC;
                end else begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_EXEC: begin
                aluop   = ex_aluop;
                alusrc  = ex_alusrc;
                signop  = ex_signop;
                reg2loc = ex_reg2loc;
                case (cls_q)
                    C_B: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                        retire   = 1'b1;
                    end
                    C_CBZ: begin
                        pc_write = 1'b1;
                        pc_src   = zero;
                        retire   = 1'b1;
                    end
                    C_LDUR, C_STUR: begin
                        state_d = S_MEM;
                        wait_d  = '0;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                aluop    = ex_aluop;
                alusrc   = ex_alusrc;
                signop   = ex_signop;
                reg2loc  = ex_reg2loc;
                dmem_req = 1'b1;
                memread  = (cls_q == C_LDUR);
                memwrite = (cls_q == C_STUR);
                if (dmem_ack) begin
                    if (cls_q == C_STUR) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                aluop    = ex_aluop;
                alusrc   = ex_alusrc;
                signop   = ex_signop;
                reg2loc  = ex_reg2loc;
                regwrite = 1'b1;
                mem2reg  = (cls_q == C_LDUR);
                pc_write = 1'b1;
                retire   = 1'b1;
            end
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase

        // Every retire ends the instruction; run decides whether to continue.
        if (retire) begin
            state_d = run ? S_FETCH : S_IDLE;
            wait_d  = '0;
        end
    end

    assign instret_d = instret_q + (retire ? CNT_W'(1) : CNT_W'(0));
    assign instret   = instret_q;
    assign fault     = fault_q;
    assign halted    = (state_q == S_HALT);
    assign state_dbg = state_q;

endmodule
